dsm_seq_ctrl: RTL and testbench

//  Bring-up and run-time sequencer for the interp -> mixer -> DSM modulator chain.
//  - Holds the chain in sync reset, flushes it and warms up the dither.
//  - Soft-ramps the input gain up on enable and down on disable, mute or overload.
//  - Watches the pwm stream for stuck codes and reports overload.
//  - Sits between the system input and the chain's vin/reset pins.

---
 rtl/dsm_seq_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_dsm_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_seq_ctrl.sv
// Bring-up / run-time sequencer for the interp -> mixer -> DSM chain: reset, flush, dither warm-up, gain ramps, overload watch.
// Optional macro DSM_SEQ_OVL_CNT_EN adds the saturating ovl_events counter output.
module dsm_seq_ctrl #(
  parameter int DATA_W    = 20,
  parameter int FLUSH_CYC = 64,
  parameter int WARM_CYC  = 256,
  parameter int RAMP_STEP = 1,
  parameter int OVL_LEN   = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mute_req,
  input  logic                     ovl_clr,
  input  logic signed [DATA_W-1:0] vin_req,
  input  logic        [1:0]        pwm,
  output logic                     dsm_rst,
  output logic                     dith_en,
  output logic signed [DATA_W-1:0] vin_o,
  output logic                     ready,
  output logic                     overload,
`ifdef DSM_SEQ_OVL_CNT_EN
  output logic        [15:0]       ovl_events,
`endif
  output logic        [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_WARM    = 3'd2,
    S_RAMP_UP = 3'd3,
    S_RUN     = 3'd4,
    S_RAMP_DN = 3'd5,
    S_MUTED   = 3'd6
  } state_t;

  localparam int CNT_W = $clog2((FLUSH_CYC > WARM_CYC ? FLUSH_CYC : WARM_CYC) + 1);
  localparam int OVL_W = $clog2(OVL_LEN + 1);
  localparam logic [9:0]       GAIN_FS    = 10'd256;
  localparam logic [9:0]       STEP       = 10'(RAMP_STEP);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARM_CYC - 1);
  localparam logic [OVL_W-1:0] OVL_MAX    = OVL_W'(OVL_LEN);

  // Gain ramps saturate at both ends so a step that does not divide 256 still lands exactly.
  function automatic logic [8:0] gain_up(input logic [8:0] g);
    logic [9:0] s;
    s = {1'b0, g} + STEP;
    return (s >= GAIN_FS) ? 9'd256 : s[8:0];
  endfunction

  function automatic logic [8:0] gain_dn(input logic [8:0] g);
    logic [9:0] d;
    d = {1'b0, g} - STEP;
    return ({1'b0, g} <= STEP) ? 9'd0 : d[8:0];
  endfunction

  // Q8 gain: 256 is unity, so the arithmetic shift by 8 returns the sample unchanged at full scale.
  function automatic logic signed [DATA_W-1:0] scale(input logic signed [DATA_W-1:0] x,
                                                     input logic [8:0] g);
    logic signed [DATA_W+9:0] p;
    p = (DATA_W+10)'(x) * (DATA_W+10)'($signed({1'b0, g}));
    p = p >>> 8;
    return p[DATA_W-1:0];
  endfunction

  state_t                     state_q, state_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic        [8:0]          gain_q, gain_d;
  logic                       dsm_rst_q, dsm_rst_d;
  logic                       dith_en_q, dith_en_d;
  logic                       ready_q, ready_d;
  logic signed [DATA_W-1:0]   vin_o_q, vin_o_d;
  logic        [1:0]          pwm_prev_q, pwm_prev_d;
  logic        [OVL_W-1:0]    run_cnt_q, run_cnt_d;
  logic                       overload_q, overload_d;
  logic                       ovl_set;
  logic                       drop;
`ifdef DSM_SEQ_OVL_CNT_EN
  logic        [15:0]         ovl_events_q, ovl_events_d;
`endif

  assign drop = !enable || mute_req || overload_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gain_d  = gain_q;
    case (state_q)
      S_IDLE: begin
        gain_d = 9'd0;
        cnt_d  = '0;
        if (enable) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == FLUSH_LAST) begin
          state_d = S_WARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WARM: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WARM_LAST) begin
          state_d = S_RAMP_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // An interrupted ramp-up hands its current gain to RAMP_DN unchanged.
      S_RAMP_UP: begin
        if (drop) begin
          state_d = S_RAMP_DN;
        end else begin
          gain_d = gain_up(gain_q);
          if (gain_d == 9'd256) state_d = S_RUN;
        end
      end
      S_RUN: begin
        gain_d = 9'd256;
        if (drop) state_d = S_RAMP_DN;
      end
      S_RAMP_DN: begin
        gain_d = gain_dn(gain_q);
        if (gain_d == 9'd0) begin
          if (!enable)                      state_d = S_IDLE;
          else if (mute_req || overload_q)  state_d = S_MUTED;
          else                              state_d = S_RAMP_UP;
        end
      end
      S_MUTED: begin
        gain_d = 9'd0;
        if (!enable)                         state_d = S_IDLE;
        else if (!mute_req && !overload_q)   state_d = S_RAMP_UP;
      end
      default: begin
        state_d = S_IDLE;
        gain_d  = 9'd0;
        cnt_d   = '0;
      end
    endcase

    dsm_rst_d = (state_d == S_IDLE) || (state_d == S_FLUSH);
    dith_en_d = !dsm_rst_d;
    ready_d   = (state_d == S_RUN);
    vin_o_d   = scale(vin_req, gain_q);
  end

  // Stuck-code detector: flags only when the run length first reaches OVL_LEN, not while it sits there.
  always_comb begin
    pwm_prev_d = pwm;
    run_cnt_d  = '0;
    ovl_set    = 1'b0;
    if (!dsm_rst_q) begin
      if (pwm == pwm_prev_q)
        run_cnt_d = (run_cnt_q == OVL_MAX) ? OVL_MAX : run_cnt_q + 1'b1;
      else
        run_cnt_d = OVL_W'(1);
      ovl_set = (run_cnt_d == OVL_MAX) && (run_cnt_q != OVL_MAX);
    end
    if (ovl_clr) run_cnt_d = '0;
    if (ovl_set)      overload_d = 1'b1;
    else if (ovl_clr) overload_d = 1'b0;
    else              overload_d = overload_q;
`ifdef DSM_SEQ_OVL_CNT_EN
    ovl_events_d = ovl_events_q;
    if (overload_d && !overload_q && (ovl_events_q != 16'hFFFF))
      ovl_events_d = ovl_events_q + 16'd1;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gain_q       <= 9'd0;
      dsm_rst_q    <= 1'b1;
      dith_en_q    <= 1'b0;
      ready_q      <= 1'b0;
      vin_o_q      <= '0;
      pwm_prev_q   <= 2'b00;
      run_cnt_q    <= '0;
      overload_q   <= 1'b0;
`ifdef DSM_SEQ_OVL_CNT_EN
      ovl_events_q <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gain_q       <= gain_d;
      dsm_rst_q    <= dsm_rst_d;
      dith_en_q    <= dith_en_d;
      ready_q      <= ready_d;
      vin_o_q      <= vin_o_d;
      pwm_prev_q   <= pwm_prev_d;
      run_cnt_q    <= run_cnt_d;
      overload_q   <= overload_d;
`ifdef DSM_SEQ_OVL_CNT_EN
      ovl_events_q <= ovl_events_d;
`endif
    end
  end

  assign dsm_rst    = dsm_rst_q;
  assign dith_en    = dith_en_q;
  assign vin_o      = vin_o_q;
  assign ready      = ready_q;
  assign overload   = overload_q;
  assign state_o    = state_q;
`ifdef DSM_SEQ_OVL_CNT_EN
  assign ovl_events = ovl_events_q;
`endif

endmodule

// File: tb/tb_dsm_seq_ctrl.sv
// Scoreboard bench for dsm_seq_ctrl: expectations are queued per cycle and a monitor compares them.
module tb_dsm_seq_ctrl;

  localparam int SEL_ST = 0, SEL_RST = 1, SEL_DITH = 2, SEL_VIN = 3, SEL_RDY = 4, SEL_OVL = 5, SEL_EVT = 6;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               enable, mute_req, ovl_clr;
  logic signed [19:0] vin_req;
  logic        [1:0]  pwm = 2'b01;
  logic               dsm_rst, dith_en, ready, overload;
  logic signed [19:0] vin_o;
  logic        [2:0]  state_o;
`ifdef DSM_SEQ_OVL_CNT_EN
  logic        [15:0] ovl_events;
`endif
  logic               pwm_hold = 1'b0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [19:0] exp;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  dsm_seq_ctrl #(
    .DATA_W(20), .FLUSH_CYC(4), .WARM_CYC(8), .RAMP_STEP(64), .OVL_LEN(16)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .mute_req(mute_req),
    .ovl_clr(ovl_clr), .vin_req(vin_req), .pwm(pwm),
    .dsm_rst(dsm_rst), .dith_en(dith_en), .vin_o(vin_o), .ready(ready),
    .overload(overload),
`ifdef DSM_SEQ_OVL_CNT_EN
    .ovl_events(ovl_events),
`endif
    .state_o(state_o)
  );

  always #5 clock = ~clock;

  function automatic logic [19:0] get_sig(int sel);
    case (sel)
      SEL_ST:   return {17'd0, state_o};
      SEL_RST:  return {19'd0, dsm_rst};
      SEL_DITH: return {19'd0, dith_en};
      SEL_VIN:  return vin_o;
      SEL_RDY:  return {19'd0, ready};
      SEL_OVL:  return {19'd0, overload};
`ifdef DSM_SEQ_OVL_CNT_EN
      SEL_EVT:  return {4'd0, ovl_events};
`endif
      default:  return 20'd0;
    endcase
  endfunction

  task automatic expect_at(int c, int sel, logic [19:0] v, string n);
    exp_t e;
    e.cyc = c; e.sel = sel; e.exp = v; e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic check_tag(int c);
    logic [19:0] act;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == c) begin
        act = get_sig(sb_q[i].sel);
        checks++;
        if (act !== sb_q[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", sb_q[i].name, c, act, sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Clocked monitor: counts edges after reset release and checks that cycle's expectations.
  initial forever begin
    @(posedge clock);
    if (reset) cyc++;
    #1;
    check_tag(cyc);
  end

  // Asynchronous-reset monitor: expectations tagged -1 are checked with no clock edge.
  initial forever begin
    @(negedge reset);
    #1;
    check_tag(-1);
  end

  // pwm toggles between 01 and 11 unless held at the stuck code 10.
  initial forever begin
    @(posedge clock);
    #2;
    if (pwm_hold) pwm = 2'b10;
    else          pwm = (pwm == 2'b01) ? 2'b11 : 2'b01;
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    enable = 1'b0; mute_req = 1'b0; ovl_clr = 1'b0; vin_req = 20'h00000;

    expect_at(0, SEL_ST,   20'h0, "rst_state");
    expect_at(0, SEL_RST,  20'h1, "rst_dsm_rst");
    expect_at(0, SEL_DITH, 20'h0, "rst_dith");
    expect_at(0, SEL_VIN,  20'h0, "rst_vin");
    expect_at(0, SEL_RDY,  20'h0, "rst_ready");
    expect_at(0, SEL_OVL,  20'h0, "rst_ovl");

    // bring-up
    expect_at(1,  SEL_ST,   20'h1, "flush_enter");
    expect_at(1,  SEL_RST,  20'h1, "flush_rst");
    expect_at(4,  SEL_RST,  20'h1, "flush_last_rst");
    expect_at(4,  SEL_DITH, 20'h0, "flush_last_dith");
    expect_at(5,  SEL_ST,   20'h2, "warm_enter");
    expect_at(5,  SEL_RST,  20'h0, "warm_rst");
    expect_at(5,  SEL_DITH, 20'h1, "warm_dith");
    expect_at(12, SEL_ST,   20'h2, "warm_last");
    expect_at(13, SEL_ST,   20'h3, "ramp_up_enter");
    expect_at(13, SEL_VIN,  20'h0, "warm_vin_zero");
    expect_at(15, SEL_VIN,  20'h10000, "gain64_vin");
    expect_at(16, SEL_VIN,  20'hE0000, "gain128_neg_vin");
    expect_at(16, SEL_RDY,  20'h0, "ready_early");
    expect_at(17, SEL_VIN,  20'h30000, "gain192_vin");
    expect_at(17, SEL_ST,   20'h4, "run_enter");
    expect_at(17, SEL_RDY,  20'h1, "ready_c17");
    expect_at(18, SEL_VIN,  20'h40000, "unity_vin");
    expect_at(19, SEL_VIN,  20'h80001, "unity_neg_vin");
    expect_at(20, SEL_VIN,  20'h40000, "unity_vin2");

    // mute ramp-down and recovery
    expect_at(21, SEL_ST,   20'h5, "mute_ramp_dn");
    expect_at(21, SEL_RDY,  20'h0, "mute_ready");
    expect_at(22, SEL_VIN,  20'h40000, "dn_256_vin");
    expect_at(23, SEL_VIN,  20'h30000, "dn_192_vin");
    expect_at(24, SEL_VIN,  20'h20000, "dn_128_vin");
    expect_at(24, SEL_ST,   20'h5, "dn_still");
    expect_at(25, SEL_ST,   20'h6, "muted_enter");
    expect_at(25, SEL_VIN,  20'h10000, "dn_64_vin");
    expect_at(26, SEL_VIN,  20'h0, "muted_vin");
    expect_at(26, SEL_DITH, 20'h1, "muted_dith");
    expect_at(26, SEL_RST,  20'h0, "muted_rst");
    expect_at(27, SEL_ST,   20'h6, "muted_hold");
    expect_at(28, SEL_ST,   20'h3, "unmute_ramp_up");
    expect_at(31, SEL_VIN,  20'h20000, "reramp_128_vin");
    expect_at(32, SEL_ST,   20'h4, "rerun");
    expect_at(32, SEL_RDY,  20'h1, "rerun_ready");

    // stuck pwm overload
    expect_at(49, SEL_OVL,  20'h0, "ovl_not_yet");
    expect_at(50, SEL_OVL,  20'h1, "ovl_set");
    expect_at(50, SEL_ST,   20'h4, "ovl_run_still");
    expect_at(51, SEL_ST,   20'h5, "ovl_ramp_dn");
    expect_at(55, SEL_ST,   20'h6, "ovl_muted");
    expect_at(56, SEL_VIN,  20'h0, "ovl_muted_vin");
    expect_at(61, SEL_ST,   20'h6, "ovl_hold_muted");
    expect_at(61, SEL_OVL,  20'h1, "ovl_sticky");
    expect_at(62, SEL_OVL,  20'h0, "ovl_cleared");
    expect_at(62, SEL_ST,   20'h6, "ovl_clr_edge");
`ifdef DSM_SEQ_OVL_CNT_EN
    expect_at(62, SEL_EVT,  20'h1, "ovl_events");
`endif
    expect_at(63, SEL_ST,   20'h3, "ovl_resume");

    // disable mid ramp-up at gain 128
    expect_at(66, SEL_ST,   20'h5, "dis_ramp_dn");
    expect_at(66, SEL_VIN,  20'h20000, "dis_128_vin");
    expect_at(67, SEL_ST,   20'h5, "dis_ramp_dn2");
    expect_at(67, SEL_VIN,  20'h20000, "dis_hold128_vin");
    expect_at(68, SEL_ST,   20'h0, "dis_idle");
    expect_at(68, SEL_RST,  20'h1, "dis_rst");
    expect_at(68, SEL_DITH, 20'h0, "dis_dith");
    expect_at(68, SEL_VIN,  20'h10000, "dis_64_vin");
    expect_at(69, SEL_VIN,  20'h0, "dis_zero_vin");

    // second bring-up
    expect_at(87, SEL_ST,   20'h4, "run2");
    expect_at(89, SEL_VIN,  20'h40000, "run2_vin");

    repeat (3) @(negedge clock);
    reset = 1'b1;
    enable = 1'b1;

    wait_cyc(14); vin_req = 20'h40000;
    wait_cyc(15); vin_req = 20'hC0000;
    wait_cyc(16); vin_req = 20'h40000;
    wait_cyc(18); vin_req = 20'h80001;
    wait_cyc(19); vin_req = 20'h40000;
    wait_cyc(20); mute_req = 1'b1;
    wait_cyc(27); mute_req = 1'b0;
    wait_cyc(33); pwm_hold = 1'b1;
    wait_cyc(57); pwm_hold = 1'b0;
    wait_cyc(61); ovl_clr = 1'b1;
    wait_cyc(62); ovl_clr = 1'b0;
    wait_cyc(65); enable = 1'b0;
    wait_cyc(70); enable = 1'b1;

    // asynchronous reset in RUN
    wait_cyc(90);
    expect_at(-1, SEL_ST,   20'h0, "async_state");
    expect_at(-1, SEL_RST,  20'h1, "async_dsm_rst");
    expect_at(-1, SEL_DITH, 20'h0, "async_dith");
    expect_at(-1, SEL_VIN,  20'h0, "async_vin");
    expect_at(-1, SEL_RDY,  20'h0, "async_ready");
    expect_at(-1, SEL_OVL,  20'h0, "async_ovl");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // enable dropped in FLUSH returns straight to IDLE
    expect_at(92, SEL_ST, 20'h1, "flush_again");
    expect_at(93, SEL_ST, 20'h0, "flush_abort_idle");
    expect_at(93, SEL_RST, 20'h1, "flush_abort_rst");
    reset = 1'b1;
    wait_cyc(92); enable = 1'b0;
    wait_cyc(95);
    @(negedge clock);

    while (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s never_checked got=pending exp=cyc%0d", sb_q[0].name, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
